// File: rtl/serial_compare_ctrl.sv
// ============================================================================
// serial_compare_ctrl: bit-serial MSB-first unsigned comparator (gr/eq/le).
// Define SERIAL_COMPARE_EARLY_EXIT_EN to end RUN on the first differing bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gr,
  output logic             eq,
  output logic             le,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             found_q, found_d;
  logic             gr_q, gr_d;
  logic             eq_q, eq_d;
  logic             le_q, le_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic bit_a, bit_b;
  logic gr_bit, eq_bit, le_bit;
  logic last_bit, run_end;

  always_comb begin
    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    gr_bit   = bit_a & ~bit_b;
    eq_bit   = ~(bit_a ^ bit_b);
    le_bit   = ~bit_a & bit_b;
    last_bit = (idx_q == '0);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    run_end  = last_bit | (~found_q & ~eq_bit);
`else
    run_end  = last_bit;
`endif

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    found_d = found_q;
    gr_d    = gr_q;
    eq_d    = eq_q;
    le_d    = le_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MAX;
          found_d = 1'b0;
          gr_d    = 1'b0;
          eq_d    = 1'b1;
          le_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the most significant differing bit decides; found freezes it.
        if (!found_q && !eq_bit) begin
          gr_d    = gr_bit;
          le_d    = le_bit;
          eq_d    = 1'b0;
          found_d = 1'b1;
        end
        if (run_end) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= IDX_MAX;
      found_q     <= 1'b0;
      gr_q        <= 1'b0;
      eq_q        <= 1'b1;
      le_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      gr_q        <= gr_d;
      eq_q        <= eq_d;
      le_q        <= le_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign gr        = gr_q;
  assign eq        = eq_q;
  assign le        = le_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_compare_ctrl.sv
// ============================================================================
// tb_serial_compare_ctrl: scoreboard bench for serial_compare_ctrl (WIDTH=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_compare_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gr;
  logic             eq;
  logic             le;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic gr;
    logic eq;
    logic le;
    int   n;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gr        (gr),
    .eq        (eq),
    .le        (le),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: relational operators for the result, MSB scan for latency.
  function automatic exp_t model(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
    exp_t e;
    e.gr = (ea > eb);
    e.eq = (ea == eb);
    e.le = (ea < eb);
    e.n  = WIDTH;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (ea[k] != eb[k]) begin
        e.n = WIDTH - k;
        break;
      end
    end
`endif
    return e;
  endfunction

  // Issue one pair, optionally scramble inputs during RUN, hold the result
  // for hold cycles with out_ready low, then complete the handshake.
  task automatic run_pair(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                          input int hold, input bit scramble, input string name);
    exp_t exp;
    exp_t got;
    int   cyc;
    int   busy_cnt;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
    end
    n_cmp++;
    a        = pa;
    b        = pb;
    in_valid = 1'b1;
    sb_q.push_back(model(pa, pb));
    tick();
    in_valid = scramble;
    if (scramble) begin
      a = 8'h00;
      b = 8'hFF;
    end
    cyc      = 0;
    busy_cnt = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    exp = sb_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s out_valid_timeout: got %b want 1 within 40 cycles", name, out_valid);
      return;
    end
    got = exp;
    got.gr = gr;
    got.eq = eq;
    got.le = le;
    n_cmp++;
    if ({gr, eq, le} !== {exp.gr, exp.eq, exp.le}) begin
      n_err++;
      $display("FAIL %s result: got gr/eq/le=%b%b%b want %b%b%b",
               name, got.gr, got.eq, got.le, exp.gr, exp.eq, exp.le);
    end
    n_cmp++;
    if (cyc !== exp.n) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp.n);
    end
    n_cmp++;
    if (busy_cnt !== exp.n) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp.n);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, in_ready, gr, eq, le} !== {2'b10, exp.gr, exp.eq, exp.le}) begin
        n_err++;
        $display("FAIL %s hold%0d: got v/r/gr/eq/le=%b%b%b%b%b want 10%b%b%b",
                 name, i, out_valid, in_ready, gr, eq, le, exp.gr, exp.eq, exp.le);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL %s after_handshake: got v/r/busy=%b%b%b want 010",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready, out_valid, busy, gr, eq, le} !== 6'b100010) begin
      n_err++;
      $display("FAIL reset_state: got r/v/busy/gr/eq/le=%b%b%b%b%b%b want 100010",
               in_ready, out_valid, busy, gr, eq, le);
    end
  endtask

  task automatic test_basic();
    run_pair(8'hA5, 8'hA5, 0, 1'b0, "equal_a5");
    run_pair(8'h80, 8'h7F, 0, 1'b0, "msb_gr");
    run_pair(8'h12, 8'h13, 0, 1'b0, "lsb_le");
    run_pair(8'h00, 8'h00, 0, 1'b0, "zero_eq");
    run_pair(8'h3C, 8'h3D, 0, 1'b0, "mid_le");
  endtask

  task automatic test_hold();
    run_pair(8'hFF, 8'h00, 5, 1'b0, "hold_ff_00");
  endtask

  task automatic test_abort();
    int vcnt;
    a        = 8'h01;
    b        = 8'h02;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({in_ready, out_valid, busy, gr, eq, le} !== 6'b100010) begin
      n_err++;
      $display("FAIL abort_reset_state: got r/v/busy/gr/eq/le=%b%b%b%b%b%b want 100010",
               in_ready, out_valid, busy, gr, eq, le);
    end
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) vcnt++;
    end
    n_cmp++;
    if (vcnt !== 0) begin
      n_err++;
      $display("FAIL abort_no_result: got %0d out_valid cycles want 0", vcnt);
    end
    run_pair(8'h02, 8'h01, 0, 1'b0, "after_abort");
  endtask

  task automatic test_scramble();
    run_pair(8'h40, 8'h20, 0, 1'b1, "scramble_40_20");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom_range(0, 255));
      rb = (i % 3 == 0) ? ra : WIDTH'($urandom_range(0, 255));
      run_pair(ra, rb, i % 2, 1'b0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_scramble();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, minimum 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 out_valid  output  1  result held on gr/eq/le.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 gr  output  1  A > B.
REQ-011 eq  output  1  A == B.
REQ-012 le  output  1  A < B.
REQ-013 busy  output  1  comparison in progress (state RUN).

Function
REQ-014 The block SHALL compare a and b serially, one bit per clock, MSB first, using a single per-bit compare: gr_bit = a_i & ~b_i, eq_bit = ~(a_i ^ b_i), le_bit = ~a_i & b_i.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state == IDLE), out_valid = (state == DONE), busy = (state == RUN).
REQ-016 In IDLE, when in_valid & in_ready, the block SHALL capture a and b into internal registers, set bit index to WIDTH-1, clear the found flag and go to RUN.
REQ-017 In RUN, for each cycle, the block SHALL compare the captured bits at the current index; the first differing bit SHALL set gr/le from that bit's result and clear eq.
REQ-018 In RUN, when the index is 0, or on early exit (REQ-030), the block SHALL go to DONE; otherwise the index SHALL decrement by 1.
REQ-019 If no bit differs across all WIDTH bits, the block SHALL report gr=0, eq=1, le=0.
REQ-020 When out_valid is high, exactly one of gr, eq, le SHALL be high.
REQ-021 In DONE, gr/eq/le SHALL hold stable until out_valid & out_ready; the FSM then SHALL go to IDLE.
REQ-022 The DONE->IDLE transition SHALL NOT accept a new pair in the same cycle; in_ready rises the cycle after the result handshake.
REQ-023 Changes on a, b or in_valid while in RUN or DONE SHALL be ignored; the captured operands are used.
REQ-024 Latency: with N = number of RUN cycles, out_valid SHALL rise N cycles after the accepting edge.
REQ-025 Comparisons SHALL be back-to-back limited only by the handshakes; throughput with out_ready held high is one result per N+2 cycles.

Reset
REQ-026 While rst_n is low at a rising clk edge, the state SHALL become IDLE, with out_valid=0, busy=0, gr=0, eq=1, le=0, index=WIDTH-1 and found=0.
REQ-027 A reset asserted during RUN or DONE SHALL abort the comparison and discard its result; no out_valid pulse SHALL follow.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-029 Macro SERIAL_COMPARE_EARLY_EXIT_EN SHALL select the termination policy.
REQ-030 With SERIAL_COMPARE_EARLY_EXIT_EN defined, RUN SHALL end on the first differing bit k (MSB = WIDTH-1), giving N = WIDTH-k; for equal operands, N = WIDTH.
REQ-031 Without SERIAL_COMPARE_EARLY_EXIT_EN, RUN SHALL always last N = WIDTH cycles; the found flag SHALL latch the first mismatch, and later bits SHALL NOT alter gr/eq/le.
REQ-032 With either setting, the reported gr/eq/le for a given a/b SHALL be identical.

Verification (WIDTH=8)
REQ-033 Reset, then a=0xA5, b=0xA5, in_valid=1 -> out_valid 8 cycles after accept with gr=0, eq=1, le=0.
REQ-034 a=0x80, b=0x7F -> gr=1, eq=0, le=0; with EARLY_EXIT_EN, N=1; without it, N=8.
REQ-035 a=0x12, b=0x13 -> le=1 with N=8 in both configurations; busy high for exactly 8 cycles.
REQ-036 Result a=0xFF, b=0x00 with out_ready held low for 5 cycles -> gr=1 stable, out_valid high, in_ready low throughout; IDLE one cycle after out_ready=1.
REQ-037 rst_n low on the 3rd RUN cycle of a=0x01, b=0x02 -> IDLE next cycle, outputs at reset values, no out_valid; a following pair a=0x02, b=0x01 yields gr=1.
REQ-038 Operands toggled to 0x00/0xFF during RUN after accepting a=0x40, b=0x20 -> result gr=1, unaffected.
